// File: rtl/cpu_record_extractor.sv
// rtl/cpu_record_extractor.sv - decodes CPU trace record fields and commits them on checker acceptance
// Optional record counters: define CPU_RECORD_COUNT_EN.
module cpu_record_extractor #(
    parameter int TIME_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    input  logic [1:0]        format_type,
    output logic              rec_valid,
    output logic [1:0]        rec_kind,
    output logic [TIME_W-1:0] rec_time,
    output logic [31:0]       rec_pc,
    output logic [31:0]       rec_dest,
    output logic [31:0]       rec_data,
`ifdef CPU_RECORD_COUNT_EN
    output logic [CNT_W-1:0]  reg_count,
    output logic [CNT_W-1:0]  mem_count,
`endif
    output logic              kind_mismatch
);

    typedef enum logic [2:0] {S_IDLE, S_TIME, S_PC, S_SEP, S_DEST, S_LT, S_DATA} state_t;

    state_t             state, state_nxt;
    logic [TIME_W-1:0]  time_acc, pend_time;
    logic [31:0]        pc_acc, dest_acc, data_acc;
    logic [31:0]        pend_pc, pend_dest, pend_data;
    logic [1:0]         kind_acc, pend_kind;

    logic       is_dec, is_hex, dest_digit;
    logic [3:0] dval;
    logic       acc_clear, time_en, pc_en, dest_en, data_en, kind_reg, kind_mem, capture;

    always_comb begin
        is_dec     = (char >= "0") && (char <= "9");
        is_hex     = is_dec || ((char >= "a") && (char <= "f"));
        dval       = is_dec ? char[3:0] : (char[3:0] + 4'd9);
        dest_digit = (kind_acc == 2'b01) ? is_dec : is_hex;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = (char == "^") ? S_TIME : S_IDLE;
            S_TIME: if (is_dec) state_nxt = S_TIME;
                    else if (char == "@") state_nxt = S_PC;
            S_PC:   if (is_hex) state_nxt = S_PC;
                    else if (char == ":") state_nxt = S_SEP;
            S_SEP:  if (char == " ") state_nxt = S_SEP;
                    else if (char == "$" || char == "*") state_nxt = S_DEST;
            S_DEST: if (dest_digit || char == " ") state_nxt = S_DEST;
                    else if (char == "<") state_nxt = S_LT;
            S_LT:   if (char == "=") state_nxt = S_DATA;
            S_DATA: if (is_hex || char == " ") state_nxt = S_DATA;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        acc_clear = (state == S_IDLE) && (char == "^");
        time_en   = (state == S_TIME) && is_dec;
        pc_en     = (state == S_PC) && is_hex;
        kind_reg  = (state == S_SEP) && (char == "$");
        kind_mem  = (state == S_SEP) && (char == "*");
        dest_en   = (state == S_DEST) && dest_digit;
        data_en   = (state == S_DATA) && is_hex;
        capture   = (state == S_DATA) && (char == "#");
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            time_acc  <= '0;
            pc_acc    <= '0;
            dest_acc  <= '0;
            data_acc  <= '0;
            kind_acc  <= '0;
            pend_time <= '0;
            pend_pc   <= '0;
            pend_dest <= '0;
            pend_data <= '0;
            pend_kind <= '0;
        end else begin
            if (acc_clear) begin
                time_acc <= '0;
                pc_acc   <= '0;
                dest_acc <= '0;
                data_acc <= '0;
                kind_acc <= '0;
            end
            if (time_en) time_acc <= (time_acc * TIME_W'(10)) + TIME_W'(dval);
            if (pc_en)   pc_acc   <= {pc_acc[27:0], dval};
            if (kind_reg) kind_acc <= 2'b01;
            if (kind_mem) kind_acc <= 2'b10;
            if (dest_en) begin
                if (kind_acc == 2'b01) dest_acc <= (dest_acc * 32'd10) + {28'd0, dval};
                else                   dest_acc <= {dest_acc[27:0], dval};
            end
            if (data_en) data_acc <= {data_acc[27:0], dval};
            // Pending copy decouples the commit from a new record starting right behind it.
            if (capture) begin
                pend_time <= time_acc;
                pend_pc   <= pc_acc;
                pend_dest <= dest_acc;
                pend_data <= data_acc;
                pend_kind <= kind_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rec_valid     <= 1'b0;
            rec_kind      <= '0;
            rec_time      <= '0;
            rec_pc        <= '0;
            rec_dest      <= '0;
            rec_data      <= '0;
            kind_mismatch <= 1'b0;
        end else if (format_type != 2'b00) begin
            rec_valid     <= 1'b1;
            rec_kind      <= format_type;
            rec_time      <= pend_time;
            rec_pc        <= pend_pc;
            rec_dest      <= pend_dest;
            rec_data      <= pend_data;
            kind_mismatch <= (pend_kind != format_type);
        end else begin
            rec_valid     <= 1'b0;
            kind_mismatch <= 1'b0;
        end
    end

`ifdef CPU_RECORD_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_count <= '0;
            mem_count <= '0;
        end else begin
            if (format_type == 2'b01 && reg_count != {CNT_W{1'b1}}) reg_count <= reg_count + 1'b1;
            if (format_type == 2'b10 && mem_count != {CNT_W{1'b1}}) mem_count <= mem_count + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_cpu_record_extractor.sv
// tb/tb_cpu_record_extractor.sv - scoreboard bench for cpu_record_extractor
module tb_cpu_record_extractor;

    localparam int TIME_W = 16;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        char = 8'h00;
    logic [1:0]        format_type = 2'b00;
    logic              rec_valid, kind_mismatch;
    logic [1:0]        rec_kind;
    logic [TIME_W-1:0] rec_time;
    logic [31:0]       rec_pc, rec_dest, rec_data;
`ifdef CPU_RECORD_COUNT_EN
    logic [CNT_W-1:0]  reg_count, mem_count;
`endif

    cpu_record_extractor #(.TIME_W(TIME_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .char(char), .format_type(format_type),
        .rec_valid(rec_valid), .rec_kind(rec_kind), .rec_time(rec_time),
        .rec_pc(rec_pc), .rec_dest(rec_dest), .rec_data(rec_data),
`ifdef CPU_RECORD_COUNT_EN
        .reg_count(reg_count), .mem_count(mem_count),
`endif
        .kind_mismatch(kind_mismatch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] t, pc, dest, data;
        logic        mm;
        int          at;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;
    logic [1:0] ft_next = 2'b00;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        char = c;
        format_type = ft_next;
        ft_next = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    // ft models the checker verdict presented the cycle after '#'; pk is the kind the text encodes.
    task automatic send_rec(input string s, input logic [1:0] ft, input logic [1:0] pk,
                            input logic [31:0] t, input logic [31:0] pc,
                            input logic [31:0] dest, input logic [31:0] data);
        exp_t e;
        send_str(s);
        ft_next = ft;
        if (ft != 2'b00) begin
            e.kind = ft; e.t = t; e.pc = pc; e.dest = dest; e.data = data;
            e.mm = (pk != ft); e.at = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send_char(8'h00);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_valid"}, 32'(rec_valid), 32'd0);
        chk({n, "_kind"}, 32'(rec_kind), 32'd0);
        chk({n, "_time"}, 32'(rec_time), 32'd0);
        chk({n, "_pc"}, rec_pc, 32'd0);
        chk({n, "_dest"}, rec_dest, 32'd0);
        chk({n, "_data"}, rec_data, 32'd0);
        chk({n, "_mm"}, 32'(kind_mismatch), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rec_valid) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_strobe actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(e.at));
                chk("kind", 32'(rec_kind), 32'(e.kind));
                chk("time", 32'(rec_time), e.t);
                chk("pc", rec_pc, e.pc);
                chk("dest", rec_dest, e.dest);
                chk("data", rec_data, e.data);
                chk("kind_mismatch", 32'(kind_mismatch), 32'(e.mm));
            end
        end else if (kind_mismatch) begin
            total++; bad++;
            $display("FAIL stray_mismatch actual=1 expected=0 cyc=%0d", cyc);
        end
    end

    initial begin
        idle(2);
        chk_zero("reset");
`ifdef CPU_RECORD_COUNT_EN
        chk("reset_reg_count", 32'(reg_count), 32'd0);
        chk("reset_mem_count", 32'(mem_count), 32'd0);
`endif
        reset = 1'b1;
        idle(2);

        send_rec("^10@00003000: $ 8 <= 0000001f#", 2'b01, 2'b01, 10, 32'h3000, 8, 32'h1f);
        idle(3);
        send_rec("^1234@0000ab00: *0000ff10 <=  deadbeef#", 2'b10, 2'b10, 1234, 32'hab00, 32'hff10, 32'hdeadbeef);
        idle(3);

        send_rec("^1@3000: $1 <= 1#", 2'b00, 2'b01, 0, 0, 0, 0);
        idle(4);
        chk("hold_valid", 32'(rec_valid), 32'd0);
        chk("hold_kind", 32'(rec_kind), 32'd2);
        chk("hold_time", 32'(rec_time), 32'd1234);
        chk("hold_pc", rec_pc, 32'h0000ab00);
        chk("hold_dest", rec_dest, 32'h0000ff10);
        chk("hold_data", rec_data, 32'hdeadbeef);

        send_rec("^20@00003000: $ 1 <= 00000005#", 2'b01, 2'b01, 20, 32'h3000, 1, 5);
        send_rec("^21@00003004: $ 2 <= 00000006#", 2'b01, 2'b01, 21, 32'h3004, 2, 6);
        idle(3);

        // 70000 truncates to 4464 in 16 bits; checker verdict disagrees with the '$' kind.
        send_rec("^70000@ffffffff: $31 <= ffffffff#", 2'b10, 2'b01, 4464, 32'hffffffff, 31, 32'hffffffff);
        idle(3);

        send_str("^30@00003008: $ 3 <= 0000");
        reset = 1'b0;
        send_char("0");
        reset = 1'b1;
        chk_zero("abort");
        send_str("007#");
        idle(3);
        chk_zero("abort_hold");
        send_rec("^40@0000300c: $ 4 <= 00000009#", 2'b01, 2'b01, 40, 32'h300c, 4, 9);
        idle(3);

`ifdef CPU_RECORD_COUNT_EN
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("cnt_clr_reg", 32'(reg_count), 32'd0);
        chk("cnt_clr_mem", 32'(mem_count), 32'd0);
        for (int i = 0; i < 5; i++)
            send_rec("^1@00000000: $1 <= 00000001#", 2'b01, 2'b01, 1, 0, 1, 1);
        send_rec("^2@00000004: *00000010 <= 00000002#", 2'b10, 2'b10, 2, 4, 32'h10, 2);
        idle(3);
        chk("reg_count_sat", 32'(reg_count), 32'd3);
        chk("mem_count", 32'(mem_count), 32'd1);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
